// File: rtl/multi_bank_frame_buffer.sv
// N-bank single-clock frame buffer: a streaming writer fills banks in order, a reader
// random-accesses the oldest committed bank and releases it when done.
module multi_bank_frame_buffer #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAME_LEN    = 1024,
  parameter int NUM_BANKS    = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                                                 clk_in,
  input  logic                                                 rst_in,
  input  logic                                                 wr_valid_in,
  input  logic [DATA_WIDTH-1:0]                                wr_data_in,
  output logic                                                 wr_ready_out,
  output logic                                                 wr_frame_done_out,
  input  logic                                                 rd_en_in,
  input  logic [$clog2(FRAME_LEN)-1:0]                         rd_addr_in,
  input  logic                                                 rd_release_in,
  output logic                                                 rd_frame_avail_out,
  output logic [(NUM_BANKS < 2 ? 1 : $clog2(NUM_BANKS))-1:0]   rd_bank_out,
  output logic [DATA_WIDTH-1:0]                                rd_data_out,
  output logic                                                 rd_valid_out,
  output logic [$clog2(NUM_BANKS+1)-1:0]                       frames_ready_out,
  output logic                                                 overflow_out
);

  localparam int IW    = $clog2(FRAME_LEN);
  localparam int BW    = (NUM_BANKS < 2) ? 1 : $clog2(NUM_BANKS);
  localparam int CW    = $clog2(NUM_BANKS + 1);
  localparam int DEPTH = NUM_BANKS * FRAME_LEN;

  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
  localparam logic [BW-1:0] BANK_LAST = BW'(NUM_BANKS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(NUM_BANKS);
  // With a single-cycle read path the RAM output register is the port, so it must clear.
  localparam bit            RST_Q0    = (READ_LATENCY == 1);

  // Bank count need not be a power of two, so wrap by compare.
  function automatic logic [BW-1:0] bank_next(input logic [BW-1:0] b);
    return (b == BANK_LAST) ? '0 : b + BW'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [BW-1:0] wr_bank;
  logic [IW-1:0] wr_idx;
  logic [BW-1:0] rd_bank;
  logic [CW-1:0] full_cnt;
  logic          frame_done;
  logic          overflow;

  logic wr_acc;
  logic commit;
  logic rel;
  logic rd_acc;

  assign wr_ready_out       = (full_cnt < CNT_FULL);
  assign rd_frame_avail_out = (full_cnt != '0);
  assign rd_bank_out        = rd_bank;
  assign frames_ready_out   = full_cnt;
  assign wr_frame_done_out  = frame_done;
  assign overflow_out       = overflow;

  assign wr_acc = wr_valid_in & wr_ready_out;
  assign commit = wr_acc & (wr_idx == IDX_LAST);
  assign rel    = rd_release_in & rd_frame_avail_out;
  assign rd_acc = rd_en_in & rd_frame_avail_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_bank    <= '0;
      wr_idx     <= '0;
      rd_bank    <= '0;
      full_cnt   <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= commit;
      if (wr_valid_in && !wr_ready_out) overflow <= 1'b1;
      if (wr_acc) wr_idx <= commit ? '0 : wr_idx + IW'(1);
      if (commit) wr_bank <= bank_next(wr_bank);
      if (rel) rd_bank <= bank_next(rd_bank);
      if (commit && !rel)      full_cnt <= full_cnt + CW'(1);
      else if (!commit && rel) full_cnt <= full_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_acc) mem[{wr_bank, wr_idx}] <= wr_data_in;
  end

  // Stage p0: RAM read register, captured at the request edge so later writes cannot disturb it
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] rd_q_p0;

  always_ff @(posedge clk_in) begin
    if (rst_in) vld_p0 <= 1'b0;
    else        vld_p0 <= rd_acc;
  end

  always_ff @(posedge clk_in) begin
    if (RST_Q0 && rst_in) rd_q_p0 <= '0;
    else if (rd_acc)      rd_q_p0 <= mem[{rd_bank, rd_addr_in}];
  end

  generate
    if (READ_LATENCY == 2) begin : g_out_reg
      // Stage p1: output register; loads only on a valid beat so the port holds otherwise
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] rd_q_p1;

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          vld_p1  <= 1'b0;
          rd_q_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) rd_q_p1 <= rd_q_p0;
        end
      end

      assign rd_valid_out = vld_p1;
      assign rd_data_out  = rd_q_p1;
    end else begin : g_no_out_reg
      assign rd_valid_out = vld_p0;
      assign rd_data_out  = rd_q_p0;
    end
  endgenerate

endmodule

// File: tb/tb_multi_bank_frame_buffer.sv
// Directed bench: a 2-bank registered-output instance driven from a vector table and hand
// sequences, plus a 3-bank single-latency instance streaming five frames.
module tb_multi_bank_frame_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: FRAME_LEN 8, 2 banks, READ_LATENCY 2
  logic        a_wv, a_re, a_rr;
  logic [15:0] a_wd;
  logic [2:0]  a_ra;
  logic        a_rdy, a_done, a_av, a_bank, a_vld, a_ovf;
  logic [15:0] a_dat;
  logic [1:0]  a_fr;

  multi_bank_frame_buffer #(.DATA_WIDTH(16), .FRAME_LEN(8), .NUM_BANKS(2), .READ_LATENCY(2)) dut_a (
    .clk_in(clk), .rst_in(rst), .wr_valid_in(a_wv), .wr_data_in(a_wd), .wr_ready_out(a_rdy),
    .wr_frame_done_out(a_done), .rd_en_in(a_re), .rd_addr_in(a_ra), .rd_release_in(a_rr),
    .rd_frame_avail_out(a_av), .rd_bank_out(a_bank), .rd_data_out(a_dat), .rd_valid_out(a_vld),
    .frames_ready_out(a_fr), .overflow_out(a_ovf));

  // Instance B: FRAME_LEN 8, 3 banks, READ_LATENCY 1
  logic        b_wv, b_re, b_rr;
  logic [15:0] b_wd;
  logic [2:0]  b_ra;
  logic        b_rdy, b_done, b_av, b_vld, b_ovf;
  logic [1:0]  b_bank;
  logic [15:0] b_dat;
  logic [1:0]  b_fr;

  multi_bank_frame_buffer #(.DATA_WIDTH(16), .FRAME_LEN(8), .NUM_BANKS(3), .READ_LATENCY(1)) dut_b (
    .clk_in(clk), .rst_in(rst), .wr_valid_in(b_wv), .wr_data_in(b_wd), .wr_ready_out(b_rdy),
    .wr_frame_done_out(b_done), .rd_en_in(b_re), .rd_addr_in(b_ra), .rd_release_in(b_rr),
    .rd_frame_avail_out(b_av), .rd_bank_out(b_bank), .rd_data_out(b_dat), .rd_valid_out(b_vld),
    .frames_ready_out(b_fr), .overflow_out(b_ovf));

  typedef struct packed {
    logic        wv;
    logic [15:0] wd;
    logic        re;
    logic [2:0]  ra;
    logic        rr;
    logic        e_rdy;
    logic        e_done;
    logic        e_av;
    logic        e_bank;
    logic        e_vld;
    logic [15:0] e_dat;
    logic [1:0]  e_fr;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic wv, input logic [15:0] wd, input logic re,
                              input logic [2:0] ra, input logic rr, input logic e_rdy,
                              input logic e_done, input logic e_av, input logic e_bank,
                              input logic e_vld, input logic [15:0] e_dat,
                              input logic [1:0] e_fr, input logic e_ovf);
    vec_t v;
    v.wv = wv; v.wd = wd; v.re = re; v.ra = ra; v.rr = rr;
    v.e_rdy = e_rdy; v.e_done = e_done; v.e_av = e_av; v.e_bank = e_bank;
    v.e_vld = e_vld; v.e_dat = e_dat; v.e_fr = e_fr; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic rdy, input logic done, input logic av,
                       input logic bank, input logic vld, input logic [15:0] dat,
                       input logic [1:0] fr, input logic ovf);
    chk({tag, ".wr_ready"},     32'(a_rdy),  32'(rdy));
    chk({tag, ".frame_done"},   32'(a_done), 32'(done));
    chk({tag, ".avail"},        32'(a_av),   32'(av));
    chk({tag, ".rd_bank"},      32'(a_bank), 32'(bank));
    chk({tag, ".rd_valid"},     32'(a_vld),  32'(vld));
    chk({tag, ".rd_data"},      32'(a_dat),  32'(dat));
    chk({tag, ".frames_ready"}, 32'(a_fr),   32'(fr));
    chk({tag, ".overflow"},     32'(a_ovf),  32'(ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_wv = 0; a_wd = '0; a_re = 0; a_ra = '0; a_rr = 0;
    b_wv = 0; b_wd = '0; b_re = 0; b_ra = '0; b_rr = 0;

    // Vector table for instance A: row inputs, then state visible after that edge.
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b1, 16'(i), 1'b0, 3'd0, 1'b0, 1'b1, (i == 7), (i == 7), 1'b0, 1'b0,
                       16'h0, (i == 7) ? 2'd1 : 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3, 2'd1, 1'b0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b1, 16'(16'h10 + i), 1'b0, 3'd0, 1'b0, (i != 7), (i == 7), 1'b1, 1'b0,
                       1'b0, 16'h3, (i == 7) ? 2'd2 : 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 16'hAA, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3, 2'd2, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3, 2'd2, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 2'd2, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 2'd1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 2'd1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h10, 2'd1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h17, 2'd1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h17, 2'd1, 1'b1));

    // Reset state of both instances
    tick();
    tick();
    rst = 1'b0;
    chk_a("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
    chk("reset.b_wr_ready", 32'(b_rdy), 32'd1);
    chk("reset.b_avail",    32'(b_av),  32'd0);
    chk("reset.b_rd_valid", 32'(b_vld), 32'd0);
    chk("reset.b_overflow", 32'(b_ovf), 32'd0);
    chk("reset.b_frames",   32'(b_fr),  32'd0);

    // Table: ignored read/release, first frame, pipelined reads, fill, overflow, release
    for (int r = 0; r < tbl.size(); r++) begin
      a_wv = tbl[r].wv; a_wd = tbl[r].wd; a_re = tbl[r].re; a_ra = tbl[r].ra; a_rr = tbl[r].rr;
      tick();
      chk_a($sformatf("row%0d", r), tbl[r].e_rdy, tbl[r].e_done, tbl[r].e_av, tbl[r].e_bank,
            tbl[r].e_vld, tbl[r].e_dat, tbl[r].e_fr, tbl[r].e_ovf);
    end
    a_wv = 0; a_re = 0; a_rr = 0;

    // Commit coinciding with release
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_wv = 1; a_wd = 16'(16'h30 + i);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      a_wd = 16'(16'h38 + i); a_rr = (i == 7);
      tick();
    end
    a_wv = 0; a_rr = 0;
    chk("cr.frames_ready", 32'(a_fr),   32'd1);
    chk("cr.rd_bank",      32'(a_bank), 32'd1);
    chk("cr.frame_done",   32'(a_done), 32'd1);
    chk("cr.wr_ready",     32'(a_rdy),  32'd1);
    a_re = 1; a_ra = 3'd2;
    tick();
    a_re = 0;
    tick();
    chk("cr.rd_valid", 32'(a_vld), 32'd1);
    chk("cr.rd_data",  32'(a_dat), 32'h3A);
    for (int i = 0; i < 8; i++) begin
      a_wv = 1; a_wd = 16'(16'h50 + i);
      tick();
    end
    a_wv = 0;
    chk("cr2.frames_ready", 32'(a_fr),  32'd2);
    chk("cr2.wr_ready",     32'(a_rdy), 32'd0);
    a_rr = 1;
    tick();
    a_rr = 0;
    chk("cr2.rd_bank",      32'(a_bank), 32'd0);
    chk("cr2.frames_ready", 32'(a_fr),   32'd1);
    a_re = 1; a_ra = 3'd5;
    tick();
    a_re = 0;
    tick();
    chk("cr2.rd_valid", 32'(a_vld), 32'd1);
    chk("cr2.rd_data",  32'(a_dat), 32'h55);

    // Reset with reads in flight and a partial frame written
    a_wv = 1; a_wd = 16'h70;
    tick();
    a_wd = 16'h71;
    tick();
    a_wd = 16'h72; a_re = 1; a_ra = 3'd1;
    tick();
    a_wd = 16'h73; a_ra = 3'd2;
    tick();
    chk("mid.rd_valid", 32'(a_vld), 32'd1);
    chk("mid.rd_data",  32'(a_dat), 32'h51);
    a_wv = 0; a_re = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_a("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
    tick();
    chk("rst_mid.flushed", 32'(a_vld), 32'd0);
    for (int i = 0; i < 8; i++) begin
      a_wv = 1; a_wd = 16'(16'h60 + i);
      tick();
    end
    a_wv = 0;
    chk("post.frame_done",   32'(a_done), 32'd1);
    chk("post.frames_ready", 32'(a_fr),   32'd1);
    chk("post.rd_bank",      32'(a_bank), 32'd0);
    a_re = 1; a_ra = 3'd0;
    tick();
    a_ra = 3'd7;
    tick();
    chk("post.rd0_valid", 32'(a_vld), 32'd1);
    chk("post.rd0_data",  32'(a_dat), 32'h60);
    a_re = 0;
    tick();
    chk("post.rd7_valid", 32'(a_vld), 32'd1);
    chk("post.rd7_data",  32'(a_dat), 32'h67);

    // Instance B: five frames through three banks, writer running two frames ahead
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) begin
        b_wv = 1; b_wd = 16'(f * 16 + i);
        tick();
      end
    b_wv = 0;
    chk("b.prefill_frames", 32'(b_fr), 32'd2);
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("b.f%0d.rd_bank", f), 32'(b_bank), 32'(f % 3));
      for (int i = 0; i < 8; i++) begin
        b_re = 1; b_ra = 3'(7 - i);
        b_wv = (f + 2 < 5); b_wd = 16'((f + 2) * 16 + i);
        tick();
        chk($sformatf("b.f%0d.i%0d.valid", f, i), 32'(b_vld), 32'd1);
        chk($sformatf("b.f%0d.i%0d.data", f, i),  32'(b_dat), 32'(f * 16 + 7 - i));
      end
      b_re = 0; b_wv = 0; b_rr = 1;
      tick();
      b_rr = 0;
      chk($sformatf("b.f%0d.valid_low", f), 32'(b_vld), 32'd0);
      chk($sformatf("b.f%0d.frames", f),    32'(b_fr),  32'((f <= 2) ? 2 : 4 - f));
    end
    chk("b.end_avail",    32'(b_av),  32'd0);
    chk("b.end_overflow", 32'(b_ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
